// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage valid/ready add/subtract pipeline with carry chaining.
// S0 holds the operand beat; the adder works combinationally from S0; S1 holds
// the result. Optional signed saturation is enabled by defining ADDSUB_PIPE_SAT_EN.
module addsub_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op_in,
    input  logic             sat_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int unsigned W1  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    // Stage 0 operand registers
    logic             s0_valid;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic [1:0]       s0_op;

    // Carry from the most recent result loaded into S1, feeds ops 10/11
    logic             carry_q;

    // Datapath intermediates
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y_raw;
    logic             cout_raw;
    logic             ovf_raw;
    logic [WIDTH-1:0] y_next;

    // Handshake: S1 advances when it is empty or being drained
    logic s1_load;

    assign s1_load  = s0_valid && (!out_valid || out_ready);
    assign in_ready = !s0_valid || !out_valid || out_ready;

`ifdef ADDSUB_PIPE_SAT_EN
    logic s0_sat;

    // Capture saturation request alongside the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_sat <= 1'b0;
        end else if (in_ready && in_valid) begin
            s0_sat <= sat_in;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat_in;
`endif

    // Operand stage: accept a new beat whenever S0 is free or moving on
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_op    <= 2'b00;
        end else if (in_ready) begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_a  <= a_in;
                s0_b  <= b_in;
                s0_op <= op_in;
            end
        end
    end

    // Adder: A + (B ^ sub) + cin, overflow taken from the unsaturated sum
    always_comb begin
        sub = s0_op[0];
        cin = 1'b0;
        case (s0_op)
            2'b00:   cin = 1'b0;
            2'b01:   cin = 1'b1;
            default: cin = carry_q;
        endcase
        b_eff    = s0_b ^ {WIDTH{sub}};
        sum      = W1'(s0_a) + W1'(b_eff) + W1'(cin);
        y_raw    = sum[WIDTH-1:0];
        cout_raw = sum[WIDTH];
        ovf_raw  = (s0_a[MSB] & b_eff[MSB] & ~y_raw[MSB]) |
                   (~s0_a[MSB] & ~b_eff[MSB] & y_raw[MSB]);
        y_next   = y_raw;
`ifdef ADDSUB_PIPE_SAT_EN
        if (s0_sat && ovf_raw) begin
            y_next = s0_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Result stage: load from S0, otherwise hold until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            cout_out  <= 1'b0;
            ovf_out   <= 1'b0;
            carry_q   <= 1'b0;
        end else if (s1_load) begin
            out_valid <= 1'b1;
            y_out     <= y_next;
            cout_out  <= cout_raw;
            ovf_out   <= ovf_raw;
            carry_q   <= cout_raw;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow: set on delivery of an overflowing result, set wins over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (out_valid && out_ready && ovf_out) ||
                          (ovf_sticky && !clr_sticky);
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and random stimulus against a queue-based reference
// model of the add/subtract pipeline (WIDTH=4).
module tb_addsub_pipe;

    localparam int W    = 4;
    localparam int MASK = 15;

    typedef struct {
        logic [3:0] y;
        logic       c;
        logic       o;
        int         acc_edge;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [1:0] op_in;
    logic       sat_in;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y_out;
    logic       cout_out;
    logic       ovf_out;
    logic       ovf_sticky;
    logic       clr_sticky;

    addsub_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_in      (op_in),
        .sat_in     (sat_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out),
        .cout_out   (cout_out),
        .ovf_out    (ovf_out),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    cyc      = 0;
    int    n_vec    = 0;
    int    n_err    = 0;
    bit    known    = 0;
    bit    prev_rst = 0;
    bit    m_carry  = 0;
    bit    m_sticky = 0;

    // Reference: plain integer arithmetic, overflow as "true signed result out of range"
    function automatic beat_t model(int a, int b, int op, bit sat, bit carry, int e);
        beat_t r;
        int bp, cin, s, sa, sb, sr;
        bp   = (op % 2 == 1) ? (MASK - b) : b;
        cin  = (op == 0) ? 0 : (op == 1) ? 1 : int'(carry);
        s    = a + bp + cin;
        r.y  = 4'(s & MASK);
        r.c  = 1'((s >> W) & 1);
        sa   = (a  >= 8) ? a  - 16 : a;
        sb   = (bp >= 8) ? bp - 16 : bp;
        sr   = sa + sb + cin;
        r.o  = (sr > 7) || (sr < -8);
`ifdef ADDSUB_PIPE_SAT_EN
        if (sat && r.o) r.y = (a < 8) ? 4'd7 : 4'd8;
`else
        if (sat) r.y = r.y;
`endif
        r.acc_edge = e;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check current outputs, advance the model, step past the edge
    task automatic tick();
        bit    exp_ov, exp_ir, deliver, accept, set;
        beat_t nb;
        #1;
        exp_ov = (q.size() > 0) && (q[0].acc_edge < cyc);
        exp_ir = (q.size() < 2) || out_ready;
        if (known) begin
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
            if (exp_ov) begin
                chk("y_out", 32'(y_out), 32'(q[0].y));
                chk("cout_out", 32'(cout_out), 32'(q[0].c));
                chk("ovf_out", 32'(ovf_out), 32'(q[0].o));
            end
            if (prev_rst && !rst) begin
                chk("rst_y_out", 32'(y_out), 32'd0);
                chk("rst_cout", 32'(cout_out), 32'd0);
                chk("rst_ovf", 32'(ovf_out), 32'd0);
            end
        end
        if (rst) begin
            q.delete();
            m_carry  = 0;
            m_sticky = 0;
        end else if (known) begin
            deliver = exp_ov && out_ready;
            accept  = in_valid && exp_ir;
            set     = deliver && q[0].o;
            if (deliver) void'(q.pop_front());
            m_sticky = set | (m_sticky & ~clr_sticky);
            if (accept) begin
                nb = model(int'(a_in), int'(b_in), int'(op_in), sat_in, m_carry, cyc + 1);
                m_carry = nb.c;
                q.push_back(nb);
            end
        end
        prev_rst = rst;
        @(posedge clk);
        cyc++;
        if (rst) known = 1;
        @(negedge clk);
    endtask

    task automatic drive(input bit iv, input int a, input int b, input int op,
                         input bit sat, input bit ordy, input bit clr);
        in_valid   = iv;
        a_in       = 4'(a);
        b_in       = 4'(b);
        op_in      = 2'(op);
        sat_in     = sat;
        out_ready  = ordy;
        clr_sticky = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        rst = 1;
        in_valid = 0; a_in = 0; b_in = 0; op_in = 0; sat_in = 0;
        out_ready = 1; clr_sticky = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 0;

        // Overflowing add then plain subtract
        drive(1, 7, 1, 0, 0, 1, 0);
        drive(1, 3, 5, 1, 0, 1, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Carry and borrow chains
        drive(1, 15, 1, 0, 0, 1, 0);
        drive(1, 0, 0, 2, 0, 1, 0);
        drive(1, 0, 1, 1, 0, 1, 0);
        drive(1, 0, 0, 3, 0, 1, 0);
        idle(3);

        // Backpressure: third beat must wait until out_ready returns
        drive(1, 1, 5, 0, 0, 0, 0);
        drive(1, 2, 5, 0, 0, 0, 0);
        drive(1, 3, 5, 0, 0, 0, 0);
        drive(1, 3, 5, 0, 0, 0, 0);
        drive(1, 3, 5, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Saturation requests
        drive(1, 7, 1, 0, 1, 1, 0);
        drive(1, 8, 8, 0, 1, 1, 0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, int'($urandom % 16), int'($urandom % 16),
                  int'($urandom % 4), bit'($urandom % 2), ($urandom % 4) != 0,
                  ($urandom % 8) == 0);
        end

        // Mid-stream reset with beats in flight
        drive(1, 7, 7, 0, 0, 0, 0);
        drive(1, 6, 6, 0, 0, 0, 0);
        rst = 1;
        drive(1, 5, 5, 0, 0, 1, 0);
        drive(1, 5, 5, 0, 0, 1, 0);
        rst = 0;
        idle(3);

        // More random traffic after reset
        for (int i = 0; i < 200; i++) begin
            drive(($urandom % 3) != 0, int'($urandom % 16), int'($urandom % 16),
                  int'($urandom % 4), bit'($urandom % 2), ($urandom % 3) != 0,
                  ($urandom % 6) == 0);
        end

        // Drain with a bounded budget
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        chk("drain_empty", 32'(q.size()), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port a_in  input  WIDTH  operand A.
REQ-005 SHALL have port b_in  input  WIDTH  operand B.
REQ-006 SHALL have port op_in  input  2  operation: 00 A+B, 01 A-B, 10 A+B+carry_q, 11 A-B with borrow chain (A+~B+carry_q).
REQ-007 SHALL have port sat_in  input  1  request signed saturation; used only per REQ-030.
REQ-008 SHALL have port in_valid  input  1  operand beat valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result this cycle.
REQ-012 SHALL have port y_out  output  WIDTH  result.
REQ-013 SHALL have port cout_out  output  1  carry out; for subtract, 1 = no borrow.
REQ-014 SHALL have port ovf_out  output  1  two's-complement signed overflow of this result.
REQ-015 SHALL have port ovf_sticky  output  1  OR of ovf_out over all results delivered since reset/clear.
REQ-016 SHALL have port clr_sticky  input  1  clears ovf_sticky.

Function
REQ-017 SHALL form two stages: S0 registers a/b/op/sat; arithmetic computed combinationally from S0; S1 registers y/cout/ovf.
REQ-018 A beat is accepted when in_valid && in_ready; a result is delivered when out_valid && out_ready.
REQ-019 Latency SHALL be 2 cycles from acceptance edge to out_valid high, with no backpressure.
REQ-020 S1 SHALL load when S0 valid and (S1 empty or out_ready); S0 SHALL load when S0 empty or S0 moves to S1 that cycle.
REQ-021 in_ready SHALL equal !s0_valid || !s1_valid || out_ready (combinational); full throughput of 1 beat/cycle when out_ready=1.
REQ-022 While out_valid && !out_ready, y_out/cout_out/ovf_out SHALL hold stable; no beat SHALL be lost or duplicated.
REQ-023 Arithmetic SHALL be WIDTH+1-bit: sum = A + (B ^ {WIDTH{sub}}) + cin; y_out = sum[WIDTH-1:0], cout = sum[WIDTH].
REQ-024 cin SHALL be 0 for op 00, 1 for op 01, carry_q for ops 10 and 11.
REQ-025 carry_q SHALL update to the raw cout of each result when it is loaded into S1; it holds otherwise.
REQ-026 ovf SHALL be (A[msb] & B'[msb] & ~y[msb]) | (~A[msb] & ~B'[msb] & y[msb]), with B' the possibly inverted B, computed on the unsaturated sum.
REQ-027 ovf_sticky SHALL set on the cycle a result with ovf_out=1 is delivered; clr_sticky SHALL clear it; simultaneous set and clear SHALL leave it 1.
REQ-028 A beat accepted with no predecessor since reset SHALL use carry_q=0.

Reset
REQ-029 On rst=1 at a clock edge: s0_valid=0, s1_valid=0, out_valid=0, y_out=0, cout_out=0, ovf_out=0, ovf_sticky=0, carry_q=0; in_ready=1 the cycle after; beats in flight are discarded; rst overrides all other inputs.

Configuration
REQ-030 Macro ADDSUB_PIPE_SAT_EN: when defined, a beat with sat_in=1 and ovf=1 SHALL yield y_out = 0111..1 if A[msb]=0 else 1000..0; cout_out, ovf_out and carry_q stay raw. When undefined, sat_in SHALL be ignored and y_out is always the wrapped sum.

Verification (WIDTH=4)
REQ-031 Reset: assert rst 2 cycles mid-stream -> next cycle out_valid=0, y_out=0, ovf_sticky=0, in_ready=1; in-flight beats not delivered.
REQ-032 op 00, A=7, B=1, out_ready=1 -> 2 cycles later y_out=8, cout_out=0, ovf_out=1, ovf_sticky=1 the following cycle; op 01, A=3, B=5 -> y_out=0xE, cout_out=0, ovf_out=0.
REQ-033 Chain: op 00 A=0xF B=0x1 then op 10 A=0x0 B=0x0 back-to-back -> y_out=0x0 cout=1, then y_out=0x1 cout=0; op 01 A=0 B=1 then op 11 A=0 B=0 -> 0xF cout=0, then 0xF cout=0.
REQ-034 Backpressure: out_ready=0, in_valid=1 with A=1,2,3 -> in_ready drops after 2 accepts; releasing out_ready delivers 1+B,2+B,3+B in order with no loss.
REQ-035 Saturation: op 00, A=7, B=1, sat_in=1 -> y_out=7 and ovf_out=1 with ADDSUB_PIPE_SAT_EN defined; y_out=8 without it; A=8, B=8 sat -> y_out=8, cout=1.
